// File: rtl/ysyx_22040895_mdu_pkg.sv
// ============================================================================
// Module   : ysyx_22040895_mdu_pkg
// Purpose  : Op codes, FSM states and op-decode helpers for the iterative MDU
// Revision : 1.0
// ============================================================================
`default_nettype none

package ysyx_22040895_mdu_pkg;

  localparam int MDU_OP_LEN = 4;

  localparam logic [MDU_OP_LEN-1:0] MDU_MUL    = 4'd0;
  localparam logic [MDU_OP_LEN-1:0] MDU_MULH   = 4'd1;
  localparam logic [MDU_OP_LEN-1:0] MDU_MULHSU = 4'd2;
  localparam logic [MDU_OP_LEN-1:0] MDU_MULHU  = 4'd3;
  localparam logic [MDU_OP_LEN-1:0] MDU_DIV    = 4'd4;
  localparam logic [MDU_OP_LEN-1:0] MDU_DIVU   = 4'd5;
  localparam logic [MDU_OP_LEN-1:0] MDU_REM    = 4'd6;
  localparam logic [MDU_OP_LEN-1:0] MDU_REMU   = 4'd7;
  localparam logic [MDU_OP_LEN-1:0] MDU_MULW   = 4'd8;
  localparam logic [MDU_OP_LEN-1:0] MDU_DIVW   = 4'd9;
  localparam logic [MDU_OP_LEN-1:0] MDU_DIVUW  = 4'd10;
  localparam logic [MDU_OP_LEN-1:0] MDU_REMW   = 4'd11;
  localparam logic [MDU_OP_LEN-1:0] MDU_REMUW  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_legal(input logic [MDU_OP_LEN-1:0] op);
    return op <= MDU_REMUW;
  endfunction

  function automatic logic op_is_word(input logic [MDU_OP_LEN-1:0] op);
    return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
  endfunction

  function automatic logic op_is_div(input logic [MDU_OP_LEN-1:0] op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
                      MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
  endfunction

  function automatic logic op_is_rem(input logic [MDU_OP_LEN-1:0] op);
    return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
  endfunction

  function automatic logic op_is_high(input logic [MDU_OP_LEN-1:0] op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
  endfunction

  // MUL/MULW only need the low product bits, so they run unsigned.
  function automatic logic op_signed_a(input logic [MDU_OP_LEN-1:0] op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
  endfunction

  function automatic logic op_signed_b(input logic [MDU_OP_LEN-1:0] op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040895_mdu_iter.sv
// ============================================================================
// Module   : ysyx_22040895_mdu_iter
// Purpose  : One shift-add multiply or restoring-divide step on a 2*XLEN acc
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040895_mdu_iter
  import ysyx_22040895_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              mode_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] rem_sub;

  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    rem_sub = rem_sh - {1'b0, opnd_i};
    if (mode_div) begin
      // Quotient bits enter at the bottom as the dividend shifts into the remainder half.
      if (rem_sh >= {1'b0, opnd_i}) acc_o = {rem_sub[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else                          acc_o = {rem_sh[XLEN-1:0],  acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040895_mdu.sv
// ============================================================================
// Module   : ysyx_22040895_mdu
// Purpose  : Iterative RV64M multiply/divide unit with valid/ready and flush
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040895_mdu
  import ysyx_22040895_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [MDU_OP_LEN-1:0] op_i,
  input  logic [XLEN-1:0]       op1_i,
  input  logic [XLEN-1:0]       op2_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  output logic [XLEN-1:0]       result_o,
  input  logic                  ready_i
);

  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0] CNT_WORD = CW'(HW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mdu_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d, acc_n;
  logic [XLEN-1:0]       opnd_q, opnd_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [MDU_OP_LEN-1:0] op_q, op_d;
  logic                  neg_q, neg_d;
  logic                  special_q, special_d;

  logic                  word_in, sgn_a, sgn_b, div_zero, div_ovf, special_in;
  logic [XLEN-1:0]       a_sx, a_ext, b_ext, a_mag, b_mag, min_val, spec_res;
  logic [2*XLEN-1:0]     prod_fix;
  logic [XLEN-1:0]       raw, raw_fix, final_res;

  ysyx_22040895_mdu_iter #(.XLEN(XLEN)) u_iter (
    .mode_div (op_is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_n)
  );

  // Operand conditioning: word ops are widened first, then everything is magnitude-based.
  always_comb begin
    word_in = op_is_word(op_i);
    a_sx    = {{HW{op1_i[HW-1]}}, op1_i[HW-1:0]};
    a_ext   = op1_i;
    b_ext   = op2_i;
    if (word_in) begin
      a_ext = op_signed_a(op_i) ? a_sx : {{HW{1'b0}}, op1_i[HW-1:0]};
      b_ext = op_signed_b(op_i) ? {{HW{op2_i[HW-1]}}, op2_i[HW-1:0]}
                                : {{HW{1'b0}}, op2_i[HW-1:0]};
    end
    sgn_a   = op_signed_a(op_i) & a_ext[XLEN-1];
    sgn_b   = op_signed_b(op_i) & b_ext[XLEN-1];
    a_mag   = sgn_a ? -a_ext : a_ext;
    b_mag   = sgn_b ? -b_ext : b_ext;
    min_val = word_in ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = op_is_div(op_i) && (b_ext == '0);
    div_ovf  = op_is_div(op_i) && op_signed_b(op_i) && (a_ext == min_val) && (b_ext == '1);
    special_in = !op_is_legal(op_i) || div_zero || div_ovf;
    spec_res = '0;
    if (div_zero)     spec_res = op_is_rem(op_i) ? (word_in ? a_sx : op1_i) : '1;
    else if (div_ovf) spec_res = op_is_rem(op_i) ? '0 : a_ext;
  end

  // Sign fix-up applied to the accumulator produced by the final iteration.
  always_comb begin
    prod_fix = neg_q ? -acc_n : acc_n;
    if (op_is_div(op_q)) raw = op_is_rem(op_q) ? acc_n[2*XLEN-1:XLEN] : acc_n[XLEN-1:0];
    else                 raw = {{HW{1'b0}}, acc_n[XLEN-1:HW]};
    raw_fix = neg_q ? -raw : raw;
    if (op_is_word(op_q))      final_res = {{HW{raw_fix[HW-1]}}, raw_fix[HW-1:0]};
    else if (op_is_div(op_q))  final_res = raw_fix;
    else if (op_is_high(op_q)) final_res = prod_fix[2*XLEN-1:XLEN];
    else                       final_res = prod_fix[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          op_d      = op_i;
          neg_d     = op_is_rem(op_i) ? sgn_a : (sgn_a ^ sgn_b);
          special_d = special_in;
          if (special_in) begin
            state_d = S_DIV;
            cnt_d   = CNT_ONE;
            acc_d   = {{XLEN{1'b0}}, spec_res};
          end else if (op_is_div(op_i)) begin
            state_d = S_DIV;
            cnt_d   = word_in ? CNT_WORD : CNT_FULL;
            acc_d   = {{XLEN{1'b0}}, (word_in ? (a_mag << HW) : a_mag)};
            opnd_d  = b_mag;
          end else begin
            state_d = S_MUL;
            cnt_d   = word_in ? CNT_WORD : CNT_FULL;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            opnd_d  = a_mag;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          acc_d = acc_n;
          if (cnt_q == CNT_ONE) begin
            state_d  = S_DONE;
            result_d = special_q ? acc_q[XLEN-1:0] : final_res;
          end
        end
      end
      S_DONE: begin
        if (flush_i || ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040895_mdu.sv
// ============================================================================
// Module   : tb_ysyx_22040895_mdu
// Purpose  : Self-checking bench for the iterative MDU against a behavioural model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22040895_mdu;
  import ysyx_22040895_mdu_pkg::*;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  op_i = '0;
  logic [63:0] op1_i = '0;
  logic [63:0] op2_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic [63:0] result_o;
  logic        ready_i = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic        pending = 1'b0;
  int          acc_cyc = 0;
  int          exp_lat = 0;
  logic [63:0] exp_res = '0;
  logic        mon_ev;

  ysyx_22040895_mdu #(.XLEN(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .ready_i  (ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference results straight from the RV64M arithmetic definitions.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]        p;
    logic signed [63:0]  sa, sb;
    logic [31:0]         aw, bw;
    logic signed [31:0]  saw, sbw;
    sa = a; sb = b; aw = a[31:0]; bw = b[31:0]; saw = aw; sbw = bw;
    case (op)
      MDU_MUL:    return a * b;
      MDU_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      MDU_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b};       return p[127:64]; end
      MDU_MULHU:  begin p = {64'b0, a} * {64'b0, b};             return p[127:64]; end
      MDU_DIV:    if (b == 0) return '1; else if (a == MIN64 && b == '1) return a; else return sa / sb;
      MDU_DIVU:   if (b == 0) return '1; else return a / b;
      MDU_REM:    if (b == 0) return a;  else if (a == MIN64 && b == '1) return 0; else return sa % sb;
      MDU_REMU:   if (b == 0) return a;  else return a % b;
      MDU_MULW:   return sx32(aw * bw);
      MDU_DIVW:   if (bw == 0) return '1; else if (aw == 32'h8000_0000 && bw == '1) return sx32(aw);
                  else return sx32(saw / sbw);
      MDU_DIVUW:  if (bw == 0) return '1; else return sx32(aw / bw);
      MDU_REMW:   if (bw == 0) return sx32(aw); else if (aw == 32'h8000_0000 && bw == '1) return 0;
                  else return sx32(saw % sbw);
      MDU_REMUW:  if (bw == 0) return sx32(aw); else return sx32(aw % bw);
      default:    return 0;
    endcase
  endfunction

  function automatic int lat_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic word, sgn, bz, ovf;
    if (op > MDU_REMUW) return 1;
    word = (op >= MDU_MULW);
    if (op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW}) begin
      sgn = op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
      bz  = word ? (b[31:0] == 0) : (b == 0);
      ovf = sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == MIN64 && b == '1));
      if (bz || ovf) return 1;
    end
    return word ? 32 : 64;
  endfunction

  // Every cycle: valid_o must match the model's timing; while valid, result and ready_o too.
  always @(negedge clk) begin
    if (!rst) begin
      mon_ev = pending && ((cyc - acc_cyc) >= exp_lat);
      check("valid_o", {63'b0, valid_o}, {63'b0, mon_ev});
      if (mon_ev) begin
        check("result_o", result_o, exp_res);
        check("ready_o busy", {63'b0, ready_o}, 64'd0);
      end
    end
  end

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while (!ready_o && guard < 200) begin @(posedge clk); #1; guard++; end
    check({name, " ready"}, {63'b0, ready_o}, 64'd1);
  endtask

  task automatic accept(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    op_i = op; op1_i = a; op2_i = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_i  = 4'($urandom_range(0, 15));
    op1_i = {$urandom, $urandom};
    op2_i = {$urandom, $urandom};
    acc_cyc = cyc;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat, input int hold, input string name);
    wait_ready(name);
    ready_i = (hold == 0);
    accept(op, a, b);
    exp_res = exp; exp_lat = lat; pending = 1'b1;
    while ((cyc - acc_cyc) < (lat + hold)) begin @(posedge clk); #1; end
    ready_i = 1'b1;
    @(posedge clk); #1;
    pending = 1'b0; ready_i = 1'b0;
  endtask

  task automatic directed(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input int hold, input string name);
    check({name, " model"}, model(op, a, b), exp);
    check({name, " model lat"}, 64'(lat_model(op, a, b)), 64'(lat));
    run_op(op, a, b, exp, lat, hold, name);
  endtask

  task automatic run_abort(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           input int k, input bit use_rst, input string name);
    wait_ready(name);
    ready_i = 1'b1;
    accept(op, a, b);
    repeat (k) begin @(posedge clk); #1; end
    if (use_rst) begin
      rst = 1'b1; #1;
      check({name, " rst valid_o"}, {63'b0, valid_o}, 64'd0);
      check({name, " rst ready_o"}, {63'b0, ready_o}, 64'd1);
      check({name, " rst result_o"}, result_o, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check({name, " flush ready_o"}, {63'b0, ready_o}, 64'd1);
    end
    ready_i = 1'b0;
    repeat (70) begin @(posedge clk); #1; end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return MIN64;
      3:       return 64'h0000_0000_8000_0000;
      4:       return 64'h0000_0000_FFFF_FFFF;
      5:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_op;
    logic [63:0] r_a, r_b;

    #12;
    check("reset ready_o", {63'b0, ready_o}, 64'd1);
    check("reset valid_o", {63'b0, valid_o}, 64'd0);
    check("reset result_o", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    directed(MDU_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 0, "mul 7x-3");
    directed(MDU_MULHU, MIN64, 64'd4, 64'h2, 64, 0, "mulhu");
    directed(MDU_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0, "div -7/2");
    directed(MDU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0, "rem -7/2");
    directed(MDU_DIVU,  64'd100, 64'd7, 64'd14, 64, 0, "divu");
    directed(MDU_REMU,  64'd100, 64'd7, 64'd2, 64, 10, "remu hold");
    directed(MDU_DIVW,  64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 32, 0, "divw");
    directed(MDU_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32, 0, "divuw");
    directed(MDU_DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "div by 0");
    directed(MDU_REM,   64'd5, 64'd0, 64'd5, 1, 0, "rem by 0");
    directed(MDU_DIV,   MIN64, '1, MIN64, 1, 0, "div ovf");
    directed(MDU_REM,   MIN64, '1, 64'd0, 1, 2, "rem ovf");
    directed(4'd14,     64'd9, 64'd3, 64'd0, 1, 0, "illegal");

    // Request alongside flush in IDLE must be dropped.
    valid_i = 1'b1; flush_i = 1'b1; op_i = MDU_MUL; op1_i = 64'd3; op2_i = 64'd5;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("idle flush ready_o", {63'b0, ready_o}, 64'd1);
    repeat (70) begin @(posedge clk); #1; end

    run_abort(MDU_DIV, 64'd1000, 64'd7, 20, 1'b0, "flush div");
    directed(MDU_MUL, 64'd3, 64'd5, 64'd15, 64, 0, "mul 3x5 a");
    run_abort(MDU_MUL, 64'd11, 64'd13, 30, 1'b1, "rst mul");
    directed(MDU_MUL, 64'd3, 64'd5, 64'd15, 64, 0, "mul 3x5 b");

    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = pick();
      r_b  = pick();
      run_op(r_op, r_a, r_b, model(r_op, r_a, r_b), lat_model(r_op, r_a, r_b),
             int'($urandom_range(0, 2)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
